piece_motion_ctrl: RTL and testbench

Active-piece controller for the Tetris playfield. It holds the falling piece's shape number, rotation and pixel position, and accepts spawn, move, rotate and gravity requests. It is the requesting side of the shape-size lookup interface: it drives a candidate shape_num/shape_rot out and reads the returned 16-px-granular bounding box (size_x, size_y) back to bounds-check every candidate move before committing it. Its outputs feed the sprite renderer and the board-lock logic.

---
 rtl/tetris_pkg.sv | 31 +++
 rtl/piece_bounds_chk.sv | 59 +++++
 rtl/piece_motion_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_piece_motion_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris active-piece logic: shape codes, block
// size, controller states and the kinds of move the bounds checker judges.
package tetris_pkg;

  localparam logic [2:0] SHAPE_NONE = 3'd0;
  localparam logic [2:0] SHAPE_I    = 3'd1;
  localparam logic [2:0] SHAPE_O    = 3'd2;
  localparam logic [2:0] SHAPE_T    = 3'd3;
  localparam logic [2:0] SHAPE_S    = 3'd4;
  localparam logic [2:0] SHAPE_Z    = 3'd5;
  localparam logic [2:0] SHAPE_J    = 3'd6;
  localparam logic [2:0] SHAPE_L    = 3'd7;

  // Block edge in pixels; every move steps by one block.
  localparam int CELL = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    CHECK  = 2'd2,
    LANDED = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MV_LEFT  = 2'd0,
    MV_RIGHT = 2'd1,
    MV_ROT   = 2'd2,
    MV_GRAV  = 2'd3
  } move_e;

endpackage

// File: rtl/piece_bounds_chk.sv
// Combinational legality check of a candidate piece placement against the
// playfield walls and floor. All sums are 11 bits wide so x+size cannot wrap.
module piece_bounds_chk
  import tetris_pkg::*;
#(
  parameter int FIELD_X_MIN = 240,
  parameter int FIELD_X_MAX = 400,
  parameter int FIELD_Y_MAX = 400
) (
  input  logic [1:0] mv_i,
  input  logic [9:0] c_x_i,
  input  logic [9:0] c_y_i,
  input  logic [9:0] size_x_i,
  input  logic [9:0] size_y_i,
  output logic       accept_o,
  output logic [9:0] kicked_x_o,
  output logic       hit_floor_o
);

  localparam logic [10:0] X_MIN  = 11'(FIELD_X_MIN);
  localparam logic [10:0] X_MAX  = 11'(FIELD_X_MAX);
  localparam logic [10:0] Y_MAX  = 11'(FIELD_Y_MAX);
  localparam logic [10:0] CELL11 = 11'(CELL);

  logic [10:0] x_far;
  logic [10:0] y_far;
  logic [10:0] kick_x;

  assign x_far  = {1'b0, c_x_i} + {1'b0, size_x_i};
  assign y_far  = {1'b0, c_y_i} + {1'b0, size_y_i};
  assign kick_x = X_MAX - {1'b0, size_x_i};

  // Judge the candidate; kicked_x_o is the x to commit (c_x unless kicked).
  always_comb begin
    accept_o    = 1'b0;
    kicked_x_o  = c_x_i;
    hit_floor_o = 1'b0;
    case (mv_i)
      MV_LEFT:  accept_o = ({1'b0, c_x_i} + CELL11) >= (X_MIN + CELL11);
      MV_RIGHT: accept_o = (x_far <= X_MAX);
      MV_ROT: begin
        if (y_far > Y_MAX) begin
          accept_o = 1'b0;
        end else if (x_far > X_MAX) begin
          kicked_x_o = kick_x[9:0];
          accept_o   = (kick_x >= X_MIN);
        end else begin
          accept_o = 1'b1;
        end
      end
      MV_GRAV: begin
        accept_o    = (y_far <= Y_MAX);
        hit_floor_o = (y_far > Y_MAX);
      end
      default: accept_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/piece_motion_ctrl.sv
// Active-piece controller: holds the falling piece and turns spawn / move /
// rotate / gravity requests into bounds-checked commits. A request accepted
// in ACTIVE latches a candidate, CHECK judges it in one cycle, and the result
// appears on the outputs at the CHECK->ACTIVE edge (two-cycle latency).
// Size lookup interface: this block is the requester; qry_num/qry_rot are
// always the candidate registers and qry_size_x/y must answer in the same
// cycle with no handshake, so the answer is consumed only while in CHECK.
module piece_motion_ctrl
  import tetris_pkg::*;
#(
  parameter int FIELD_X_MIN = 240,
  parameter int FIELD_X_MAX = 400,
  parameter int FIELD_Y_MIN = 80,
  parameter int FIELD_Y_MAX = 400,
  parameter int SPAWN_X     = 304
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       spawn,
  input  logic [2:0] spawn_num,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       rotate,
  input  logic       grav_tick,
  output logic [2:0] qry_num,
  output logic [1:0] qry_rot,
  input  logic [9:0] qry_size_x,
  input  logic [9:0] qry_size_y,
  output logic [2:0] shape_num,
  output logic [1:0] shape_rot,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       busy,
  output logic       landed,
  output logic [1:0] dbg_state
);

  state_e     state_q, state_d;
  move_e      mv_q, mv_d;
  logic [2:0] num_q, num_d, c_num_q, c_num_d;
  logic [1:0] rot_q, rot_d, c_rot_q, c_rot_d;
  logic [9:0] x_q, x_d, c_x_q, c_x_d;
  logic [9:0] y_q, y_d, c_y_q, c_y_d;
  logic       pend_q, pend_d;
  logic       landed_q, landed_d;

  logic       spawn_ok;
  logic       chk_accept;
  logic [9:0] chk_x;
  logic       chk_floor;

  assign spawn_ok = spawn && (spawn_num != SHAPE_NONE);

  piece_bounds_chk #(
    .FIELD_X_MIN (FIELD_X_MIN),
    .FIELD_X_MAX (FIELD_X_MAX),
    .FIELD_Y_MAX (FIELD_Y_MAX)
  ) u_chk (
    .mv_i        (mv_q),
    .c_x_i       (c_x_q),
    .c_y_i       (c_y_q),
    .size_x_i    (qry_size_x),
    .size_y_i    (qry_size_y),
    .accept_o    (chk_accept),
    .kicked_x_o  (chk_x),
    .hit_floor_o (chk_floor)
  );

  // Next-state: request arbitration in ACTIVE, commit/discard in CHECK.
  always_comb begin
    state_d  = state_q;
    mv_d     = mv_q;
    num_d    = num_q;
    rot_d    = rot_q;
    x_d      = x_q;
    y_d      = y_q;
    c_num_d  = c_num_q;
    c_rot_d  = c_rot_q;
    c_x_d    = c_x_q;
    c_y_d    = c_y_q;
    pend_d   = pend_q;
    landed_d = 1'b0;
    case (state_q)
      IDLE, LANDED, ACTIVE: begin
        if (spawn_ok) begin
          num_d   = spawn_num;
          rot_d   = 2'd0;
          x_d     = 10'(SPAWN_X);
          y_d     = 10'(FIELD_Y_MIN);
          pend_d  = 1'b0;
          state_d = ACTIVE;
        end else if (state_q == ACTIVE) begin
          c_num_d = num_q;
          c_rot_d = rot_q;
          c_x_d   = x_q;
          c_y_d   = y_q;
          if (rotate) begin
            mv_d    = MV_ROT;
            c_rot_d = rot_q + 2'd1;
            state_d = CHECK;
          end else if (move_left) begin
            mv_d    = MV_LEFT;
            c_x_d   = x_q - 10'(CELL);
            state_d = CHECK;
          end else if (move_right) begin
            mv_d    = MV_RIGHT;
            c_x_d   = x_q + 10'(CELL);
            state_d = CHECK;
          end else if (grav_tick || pend_q) begin
            mv_d    = MV_GRAV;
            c_y_d   = y_q + 10'(CELL);
            pend_d  = 1'b0;
            state_d = CHECK;
          end
          // A gravity tick losing arbitration is remembered, not dropped.
          if ((rotate || move_left || move_right) && grav_tick) begin
            pend_d = 1'b1;
          end
        end
      end
      CHECK: begin
        state_d = ACTIVE;
        if (grav_tick) begin
          pend_d = 1'b1;
        end
        if (chk_accept) begin
          num_d = c_num_q;
          rot_d = c_rot_q;
          x_d   = chk_x;
          y_d   = c_y_q;
        end else if (chk_floor) begin
          landed_d = 1'b1;
          pend_d   = 1'b0;
          state_d  = LANDED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight check.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      mv_q     <= MV_LEFT;
      num_q    <= 3'd0;
      rot_q    <= 2'd0;
      x_q      <= 10'd0;
      y_q      <= 10'd0;
      c_num_q  <= 3'd0;
      c_rot_q  <= 2'd0;
      c_x_q    <= 10'd0;
      c_y_q    <= 10'd0;
      pend_q   <= 1'b0;
      landed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mv_q     <= mv_d;
      num_q    <= num_d;
      rot_q    <= rot_d;
      x_q      <= x_d;
      y_q      <= y_d;
      c_num_q  <= c_num_d;
      c_rot_q  <= c_rot_d;
      c_x_q    <= c_x_d;
      c_y_q    <= c_y_d;
      pend_q   <= pend_d;
      landed_q <= landed_d;
    end
  end

  assign qry_num   = c_num_q;
  assign qry_rot   = c_rot_q;
  assign shape_num = num_q;
  assign shape_rot = rot_q;
  assign pos_x     = x_q;
  assign pos_y     = y_q;
  assign busy      = (state_q == CHECK);
  assign landed    = landed_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_piece_motion_ctrl.sv
// Testbench for piece_motion_ctrl: reset checks, a table of directed
// requests, hand-written multi-cycle sequences and a randomized phase
// checked against a rectangle-in-field reference model.
module tb_piece_motion_ctrl;
  import tetris_pkg::*;

  // ---------------- clock / reset ----------------
  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       spawn, move_left, move_right, rotate, grav_tick;
  logic [2:0] spawn_num;
  logic [2:0] qry_num, shape_num;
  logic [1:0] qry_rot, shape_rot, dbg_state;
  logic [9:0] qry_size_x, qry_size_y, pos_x, pos_y;
  logic       busy, landed;

  always #5 Clk = ~Clk;

  piece_motion_ctrl dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .spawn      (spawn),
    .spawn_num  (spawn_num),
    .move_left  (move_left),
    .move_right (move_right),
    .rotate     (rotate),
    .grav_tick  (grav_tick),
    .qry_num    (qry_num),
    .qry_rot    (qry_rot),
    .qry_size_x (qry_size_x),
    .qry_size_y (qry_size_y),
    .shape_num  (shape_num),
    .shape_rot  (shape_rot),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .busy       (busy),
    .landed     (landed),
    .dbg_state  (dbg_state)
  );

  // Shape-size lookup: tetromino bounding boxes in pixels.
  function automatic int w_of(input int n, input int r);
    if (n == 1) return (r % 2 == 0) ? 64 : 16;
    if (n == 2) return 32;
    if (n == 0) return 16;
    return (r % 2 == 0) ? 48 : 32;
  endfunction

  function automatic int h_of(input int n, input int r);
    if (n == 1) return (r % 2 == 0) ? 16 : 64;
    if (n == 2) return 32;
    if (n == 0) return 16;
    return (r % 2 == 0) ? 32 : 48;
  endfunction

  assign qry_size_x = 10'(w_of(int'(qry_num), int'(qry_rot)));
  assign qry_size_y = 10'(h_of(int'(qry_num), int'(qry_rot)));

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [26:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic sp, input logic [2:0] sn, input logic l,
                       input logic r, input logic ro, input logic g);
    spawn = sp; spawn_num = sn; move_left = l; move_right = r;
    rotate = ro; grav_tick = g;
  endtask

  task automatic idle_in();
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    Reset_n = 1'b0;
    tick(); tick();
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
  endtask

  // One request pulse held for one cycle, then idle until w edges have passed.
  task automatic req(input logic sp, input logic [2:0] sn, input logic l,
                     input logic r, input logic ro, input logic g, input int w);
    drive(sp, sn, l, r, ro, g);
    tick();
    idle_in();
    repeat (w - 1) tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       sp;
    logic [2:0] sn;
    logic       l, r, ro, g;
    int         waits;
    int         e_num, e_rot, e_x, e_y;
    string      name;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(input string name, input bit sp, input int sn,
                              input bit l, input bit r, input bit ro, input bit g,
                              input int w, input int en, input int er,
                              input int ex, input int ey);
    vec_t v;
    v.name = name; v.sp = sp; v.sn = 3'(sn); v.l = l; v.r = r; v.ro = ro;
    v.g = g; v.waits = w; v.e_num = en; v.e_rot = er; v.e_x = ex; v.e_y = ey;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // The piece is a rectangle; a move is legal when the moved rectangle stays
  // inside [240,400) x [.., 400). op: -1 none, 0 left, 1 right, 2 rot, 3 grav.
  int m_num, m_rot, m_x, m_y, m_op;
  bit m_piece, m_stuck, m_pend, m_land;

  task automatic model_reset();
    m_num = 0; m_rot = 0; m_x = 0; m_y = 0; m_op = -1;
    m_piece = 0; m_stuck = 0; m_pend = 0; m_land = 0;
  endtask

  task automatic model_step();
    int nr, nx, w, h;
    bit lnd;
    lnd = 0;
    if (m_op >= 0) begin
      if (grav_tick) m_pend = 1;
      case (m_op)
        0: if (m_x - 16 >= 240) m_x = m_x - 16;
        1: if (m_x + 16 + w_of(m_num, m_rot) <= 400) m_x = m_x + 16;
        2: begin
          nr = (m_rot + 1) % 4;
          w  = w_of(m_num, nr);
          h  = h_of(m_num, nr);
          nx = m_x;
          if (m_y + h <= 400) begin
            if (nx + w > 400) nx = 400 - w;
            if (nx >= 240) begin
              m_rot = nr;
              m_x   = nx;
            end
          end
        end
        default: begin
          if (m_y + 16 + h_of(m_num, m_rot) <= 400) m_y = m_y + 16;
          else begin
            lnd = 1; m_stuck = 1; m_pend = 0;
          end
        end
      endcase
      m_op = -1;
    end else if (spawn && spawn_num != 0) begin
      m_num = int'(spawn_num); m_rot = 0; m_x = 304; m_y = 80;
      m_piece = 1; m_stuck = 0; m_pend = 0;
    end else if (m_piece && !m_stuck) begin
      if (rotate) m_op = 2;
      else if (move_left) m_op = 0;
      else if (move_right) m_op = 1;
      else if (grav_tick || m_pend) begin
        m_op = 3; m_pend = 0;
      end
      if (m_op >= 0 && m_op != 3 && grav_tick) m_pend = 1;
    end
    m_land = lnd;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- test ----------------
  initial begin
    logic [26:0] act, exp;

    // reset state
    Reset_n = 1'b0;
    idle_in();
    tick(); tick();
    check("rst_num", int'(shape_num), 0);
    check("rst_x", int'(pos_x), 0);
    check("rst_y", int'(pos_y), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_landed", int'(landed), 0);
    check("rst_state", int'(dbg_state), int'(IDLE));
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();

    // requests ignored with no piece
    req(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 3);
    check("idle_ignore", int'(dbg_state), int'(IDLE));

    // directed table
    tab.push_back(mk("spawn_o",  1, 2, 0, 0, 0, 0, 1, 2, 0, 304, 80));
    tab.push_back(mk("left1",    0, 0, 1, 0, 0, 0, 2, 2, 0, 288, 80));
    tab.push_back(mk("left2",    0, 0, 1, 0, 0, 0, 2, 2, 0, 272, 80));
    tab.push_back(mk("left3",    0, 0, 1, 0, 0, 0, 2, 2, 0, 256, 80));
    tab.push_back(mk("left4",    0, 0, 1, 0, 0, 0, 2, 2, 0, 240, 80));
    tab.push_back(mk("left_wall",0, 0, 1, 0, 0, 0, 2, 2, 0, 240, 80));
    tab.push_back(mk("spawn_i",  1, 1, 0, 0, 0, 0, 1, 1, 0, 304, 80));
    tab.push_back(mk("rot_i1",   0, 0, 0, 0, 1, 0, 2, 1, 1, 304, 80));
    for (int i = 1; i <= 5; i++)
      tab.push_back(mk("right_i", 0, 0, 0, 1, 0, 0, 2, 1, 1, 304 + 16 * i, 80));
    tab.push_back(mk("right_wall",0, 0, 0, 1, 0, 0, 2, 1, 1, 384, 80));
    tab.push_back(mk("rot_kick", 0, 0, 0, 0, 1, 0, 2, 1, 2, 336, 80));
    tab.push_back(mk("rot_left", 0, 0, 1, 0, 1, 0, 4, 1, 3, 336, 80));
    tab.push_back(mk("spawn0",   1, 0, 0, 0, 0, 0, 2, 1, 3, 336, 80));
    tab.push_back(mk("spawn_t",  1, 3, 0, 0, 0, 0, 1, 3, 0, 304, 80));
    for (int i = 0; i < tab.size(); i++) begin
      req(tab[i].sp, tab[i].sn, tab[i].l, tab[i].r, tab[i].ro, tab[i].g, tab[i].waits);
      check({tab[i].name, "_num"}, int'(shape_num), tab[i].e_num);
      check({tab[i].name, "_rot"}, int'(shape_rot), tab[i].e_rot);
      check({tab[i].name, "_x"}, int'(pos_x), tab[i].e_x);
      check({tab[i].name, "_y"}, int'(pos_y), tab[i].e_y);
      check({tab[i].name, "_landed"}, int'(landed), 0);
    end

    // gravity to the floor and the landed pulse
    do_reset();
    req(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    repeat (17) req(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    check("grav_352", int'(pos_y), 352);
    req(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    check("grav_368", int'(pos_y), 368);
    check("grav_no_land", int'(landed), 0);
    req(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    check("floor_y", int'(pos_y), 368);
    check("landed_pulse", int'(landed), 1);
    check("landed_state", int'(dbg_state), int'(LANDED));
    tick();
    check("landed_1cyc", int'(landed), 0);
    req(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    check("landed_right_x", int'(pos_x), 304);
    check("landed_right_busy", int'(busy), 0);
    check("landed_hold", int'(dbg_state), int'(LANDED));

    // grav_tick during CHECK becomes the next request
    req(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("chk_busy", int'(busy), 1);
    tick();
    idle_in();
    check("pend_left_x", int'(pos_x), 288);
    check("pend_left_y", int'(pos_y), 80);
    tick(); tick();
    check("pend_grav_y", int'(pos_y), 96);

    // reset dropped mid-CHECK
    drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle_in();
    check("mid_busy", int'(busy), 1);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_num", int'(shape_num), 0);
    check("mid_rst_x", int'(pos_x), 0);
    check("mid_rst_y", int'(pos_y), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_qry", int'(qry_num), 0);
    tick(); tick();
    @(negedge Clk);
    Reset_n = 1'b1;
    tick(); tick(); tick();
    check("post_rst_x", int'(pos_x), 0);
    check("post_rst_state", int'(dbg_state), int'(IDLE));

    // randomized phase against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      spawn      = ($urandom_range(0, 99) < 3);
      spawn_num  = 3'($urandom_range(0, 7));
      rotate     = ($urandom_range(0, 99) < 15);
      move_left  = ($urandom_range(0, 99) < 15);
      move_right = ($urandom_range(0, 99) < 15);
      grav_tick  = ($urandom_range(0, 99) < 25);
      @(posedge Clk);
      model_step();
      exp_q.push_back({3'(m_num), 2'(m_rot), 10'(m_x), 10'(m_y),
                       (m_op >= 0), m_land});
      #1;
      act = {shape_num, shape_rot, pos_x, pos_y, busy, landed};
      exp = exp_q.pop_front();
      total++;
      if (act != exp) begin
        bad++;
        $display("FAIL rand_cycle%0d: got %h expected %h", c, act, exp);
      end
    end
    idle_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
